// File: rtl/l2_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : l2_miss_ctrl
//  Description : L2 miss-status holding register controller. Accepts L2
//                misses (each with an optional dirty-victim writeback), runs
//                the writeback on AXI AW/W/B, fetches the line on AR/R and
//                hands the filled line back to the L2. The AXI ID of every
//                transfer is the MSHR index.
//  Revision    : 1.0  initial release
// ============================================================================
module l2_miss_ctrl #(
  parameter int NUM_MSHR  = 4,
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 512,
  parameter int CORE_W    = 2,
  parameter int ID_W      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // miss request from the L2 lookup pipeline
  input  logic                 miss_valid_i,
  output logic                 miss_ready_o,
  input  logic [ADDR_W-1:0]    miss_addr_i,
  input  logic [CORE_W-1:0]    miss_core_i,
  input  logic                 miss_wb_i,
  input  logic [ADDR_W-1:0]    miss_wb_addr_i,
  input  logic [LINE_BITS-1:0] miss_wb_data_i,
  // fill return to the L2
  output logic                 fill_valid_o,
  input  logic                 fill_ready_i,
  output logic [ADDR_W-1:0]    fill_addr_o,
  output logic [CORE_W-1:0]    fill_core_o,
  output logic [LINE_BITS-1:0] fill_data_o,
  // AXI read address
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [ADDR_W-1:0]    ar_addr_o,
  output logic [ID_W-1:0]      ar_id_o,
  // AXI read data
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [ID_W-1:0]      r_id_i,
  input  logic [LINE_BITS-1:0] r_data_i,
  input  logic [1:0]           r_resp_i,
  // AXI write address
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [ADDR_W-1:0]    aw_addr_o,
  output logic [ID_W-1:0]      aw_id_o,
  // AXI write data
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [LINE_BITS-1:0] w_data_o,
  // AXI write response
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [ID_W-1:0]      b_id_i,
  input  logic [1:0]           b_resp_i,
  // status
  output logic                 busy_o,
  output logic                 err_o
);

  localparam logic [2:0] ST_FREE    = 3'd0;
  localparam logic [2:0] ST_WB      = 3'd1;
  localparam logic [2:0] ST_WB_RSP  = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_FILL    = 3'd5;

  // per-entry storage
  logic [2:0]           state_q   [NUM_MSHR];
  logic [2:0]           state_d   [NUM_MSHR];
  logic [ADDR_W-1:0]    addr_q    [NUM_MSHR];
  logic [ADDR_W-1:0]    addr_d    [NUM_MSHR];
  logic [ADDR_W-1:0]    wb_addr_q [NUM_MSHR];
  logic [ADDR_W-1:0]    wb_addr_d [NUM_MSHR];
  logic [CORE_W-1:0]    core_q    [NUM_MSHR];
  logic [CORE_W-1:0]    core_d    [NUM_MSHR];
  logic [LINE_BITS-1:0] buf_q     [NUM_MSHR];
  logic [LINE_BITS-1:0] buf_d     [NUM_MSHR];
  logic [NUM_MSHR-1:0]  aw_done_q, aw_done_d;
  logic [NUM_MSHR-1:0]  w_done_q,  w_done_d;

  // channel owners: which entry currently drives each output channel
  logic                 wb_act_q,   wb_act_d;
  logic [ID_W-1:0]      wb_sel_q,   wb_sel_d;
  logic                 ar_act_q,   ar_act_d;
  logic [ID_W-1:0]      ar_sel_q,   ar_sel_d;
  logic                 fill_act_q, fill_act_d;
  logic [ID_W-1:0]      fill_sel_q, fill_sel_d;

  logic                 busy_q, busy_d;
  logic                 err_q,  err_d;

  logic                 any_free;
  logic [ID_W-1:0]      free_idx;
  logic                 conflict;
  logic                 alloc;
  logic                 aw_hs, w_hs, ar_hs, fill_hs;
  logic                 r_hit, b_hit;

  // Allocation check: free slot available and no address hazard against
  // pending lines or victims whose writeback has not yet been acknowledged.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    conflict = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        any_free = 1'b1;
        free_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (state_q[i] != ST_FREE && addr_q[i] == miss_addr_i) begin
        conflict = 1'b1;
      end
      if ((state_q[i] == ST_WB || state_q[i] == ST_WB_RSP) &&
          wb_addr_q[i] == miss_addr_i) begin
        conflict = 1'b1;
      end
    end
  end

  assign miss_ready_o = any_free & ~conflict;
  assign alloc        = miss_valid_i & miss_ready_o;

  // Channel outputs come straight from the registered owner of each channel.
  assign aw_valid_o   = wb_act_q & ~aw_done_q[wb_sel_q];
  assign w_valid_o    = wb_act_q & ~w_done_q[wb_sel_q];
  assign aw_addr_o    = wb_act_q ? wb_addr_q[wb_sel_q] : '0;
  assign aw_id_o      = wb_act_q ? wb_sel_q : '0;
  assign w_data_o     = wb_act_q ? buf_q[wb_sel_q] : '0;

  assign ar_valid_o   = ar_act_q;
  assign ar_addr_o    = ar_act_q ? addr_q[ar_sel_q] : '0;
  assign ar_id_o      = ar_act_q ? ar_sel_q : '0;

  assign fill_valid_o = fill_act_q;
  assign fill_addr_o  = fill_act_q ? addr_q[fill_sel_q] : '0;
  assign fill_core_o  = fill_act_q ? core_q[fill_sel_q] : '0;
  assign fill_data_o  = fill_act_q ? buf_q[fill_sel_q] : '0;

  assign r_ready_o    = 1'b1;
  assign b_ready_o    = 1'b1;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

  assign aw_hs        = aw_valid_o & aw_ready_i;
  assign w_hs         = w_valid_o & w_ready_i;
  assign ar_hs        = ar_valid_o & ar_ready_i;
  assign fill_hs      = fill_valid_o & fill_ready_i;
  assign r_hit        = r_valid_i & (state_q[r_id_i] == ST_RD_WAIT);
  assign b_hit        = b_valid_i & (state_q[b_id_i] == ST_WB_RSP);

  // Per-entry next state; every event targets a distinct entry state so all
  // handshakes of one cycle are applied together.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wb_addr_d = wb_addr_q;
    core_d    = core_q;
    buf_d     = buf_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    for (int i = 0; i < NUM_MSHR; i++) begin
      case (state_q[i])
        ST_FREE: begin
          if (alloc && free_idx == ID_W'(i)) begin
            state_d[i]   = miss_wb_i ? ST_WB : ST_RD_REQ;
            addr_d[i]    = miss_addr_i;
            core_d[i]    = miss_core_i;
            wb_addr_d[i] = miss_wb_addr_i;
            buf_d[i]     = miss_wb_data_i;
            aw_done_d[i] = 1'b0;
            w_done_d[i]  = 1'b0;
          end
        end
        ST_WB: begin
          if (wb_act_q && wb_sel_q == ID_W'(i)) begin
            if (aw_hs) aw_done_d[i] = 1'b1;
            if (w_hs)  w_done_d[i]  = 1'b1;
            if (aw_done_d[i] && w_done_d[i]) state_d[i] = ST_WB_RSP;
          end
        end
        ST_WB_RSP: begin
          if (b_hit && b_id_i == ID_W'(i)) state_d[i] = ST_RD_REQ;
        end
        ST_RD_REQ: begin
          if (ar_hs && ar_sel_q == ID_W'(i)) state_d[i] = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_hit && r_id_i == ID_W'(i)) begin
            buf_d[i]   = r_data_i;
            state_d[i] = ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_hs && fill_sel_q == ID_W'(i)) state_d[i] = ST_FREE;
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
    // Bad responses and beats for entries not waiting on them are flagged;
    // stray beats are otherwise ignored.
    if (r_valid_i && (!r_hit || r_resp_i != 2'b00)) err_d = 1'b1;
    if (b_valid_i && (!b_hit || b_resp_i != 2'b00)) err_d = 1'b1;
  end

  // Channel ownership: keep the current owner until it leaves the channel's
  // state, otherwise hand the channel to the lowest-index waiting entry.
  always_comb begin
    wb_act_d   = 1'b0;
    wb_sel_d   = '0;
    ar_act_d   = 1'b0;
    ar_sel_d   = '0;
    fill_act_d = 1'b0;
    fill_sel_d = '0;
    busy_d     = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_d[i] == ST_WB) begin
        wb_act_d = 1'b1;
        wb_sel_d = ID_W'(i);
      end
      if (state_d[i] == ST_RD_REQ) begin
        ar_act_d = 1'b1;
        ar_sel_d = ID_W'(i);
      end
      if (state_d[i] == ST_FILL) begin
        fill_act_d = 1'b1;
        fill_sel_d = ID_W'(i);
      end
      if (state_d[i] != ST_FREE) busy_d = 1'b1;
    end
    if (wb_act_q && state_d[wb_sel_q] == ST_WB) begin
      wb_act_d = 1'b1;
      wb_sel_d = wb_sel_q;
    end
    if (ar_act_q && state_d[ar_sel_q] == ST_RD_REQ) begin
      ar_act_d = 1'b1;
      ar_sel_d = ar_sel_q;
    end
    if (fill_act_q && state_d[fill_sel_q] == ST_FILL) begin
      fill_act_d = 1'b1;
      fill_sel_d = fill_sel_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i]   <= ST_FREE;
        addr_q[i]    <= '0;
        wb_addr_q[i] <= '0;
        core_q[i]    <= '0;
        buf_q[i]     <= '0;
      end
      aw_done_q  <= '0;
      w_done_q   <= '0;
      wb_act_q   <= 1'b0;
      wb_sel_q   <= '0;
      ar_act_q   <= 1'b0;
      ar_sel_q   <= '0;
      fill_act_q <= 1'b0;
      fill_sel_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wb_addr_q  <= wb_addr_d;
      core_q     <= core_d;
      buf_q      <= buf_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wb_act_q   <= wb_act_d;
      wb_sel_q   <= wb_sel_d;
      ar_act_q   <= ar_act_d;
      ar_sel_q   <= ar_sel_d;
      fill_act_q <= fill_act_d;
      fill_sel_q <= fill_sel_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_miss_ctrl
//  Description : Self-checking bench for l2_miss_ctrl; a slot-level model of
//                the miss lifecycle predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l2_miss_ctrl;

  localparam int N  = 4;
  localparam int LB = 512;

  // model slot phases
  localparam int P_FREE  = 0;
  localparam int P_WB    = 1;
  localparam int P_WAITB = 2;
  localparam int P_AR    = 3;
  localparam int P_WAITR = 4;
  localparam int P_FILL  = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          miss_valid, miss_ready, miss_wb;
  logic [31:0]   miss_addr, miss_wb_addr;
  logic [1:0]    miss_core;
  logic [LB-1:0] miss_wb_data;
  logic          fill_valid, fill_ready;
  logic [31:0]   fill_addr;
  logic [1:0]    fill_core;
  logic [LB-1:0] fill_data;
  logic          ar_valid, ar_ready;
  logic [31:0]   ar_addr;
  logic [1:0]    ar_id;
  logic          r_valid, r_ready;
  logic [1:0]    r_id, r_resp;
  logic [LB-1:0] r_data;
  logic          aw_valid, aw_ready;
  logic [31:0]   aw_addr;
  logic [1:0]    aw_id;
  logic          w_valid, w_ready;
  logic [LB-1:0] w_data;
  logic          b_valid, b_ready;
  logic [1:0]    b_id, b_resp;
  logic          busy, err;

  l2_miss_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
    .miss_addr_i(miss_addr), .miss_core_i(miss_core), .miss_wb_i(miss_wb),
    .miss_wb_addr_i(miss_wb_addr), .miss_wb_data_i(miss_wb_data),
    .fill_valid_o(fill_valid), .fill_ready_i(fill_ready),
    .fill_addr_o(fill_addr), .fill_core_o(fill_core), .fill_data_o(fill_data),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_id_o(ar_id),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_id_i(r_id), .r_data_i(r_data),
    .r_resp_i(r_resp),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id), .b_resp_i(b_resp),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int            ph    [N];
  logic [31:0]   m_addr[N];
  logic [31:0]   m_wba [N];
  logic [1:0]    m_core[N];
  logic [LB-1:0] m_wbd [N];
  logic [LB-1:0] m_rd  [N];
  bit            m_aws [N];
  bit            m_ws  [N];
  int            wb_sel, ar_sel, fl_sel;
  bit            m_err;

  task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int k = 0; k < LB / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int lowest(input int p);
    for (int i = 0; i < N; i++) if (ph[i] == p) return i;
    return -1;
  endfunction

  // a channel owner stays until it leaves the phase; then lowest waiting slot
  function automatic int pick(input int cur, input int p);
    if (cur >= 0 && ph[cur] == p) return cur;
    return lowest(p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = P_FREE; m_aws[i] = 0; m_ws[i] = 0;
    end
    wb_sel = -1; ar_sel = -1; fl_sel = -1; m_err = 0;
  endtask

  task automatic idle();
    miss_valid = 0; miss_addr = 0; miss_core = 0; miss_wb = 0;
    miss_wb_addr = 0; miss_wb_data = 0; fill_ready = 0; ar_ready = 0;
    r_valid = 0; r_id = 0; r_data = 0; r_resp = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_id = 0; b_resp = 0;
  endtask

  // One clock: compare all outputs against the model, advance the model
  // with the handshakes the model expects, then move to the next negedge.
  task automatic step();
    bit exp_mr, exp_aw, exp_w, exp_ar, exp_f, exp_busy, hazard;
    int cur[N];
    int s;
    #1;
    hazard = 0;
    for (int i = 0; i < N; i++) begin
      if (ph[i] != P_FREE && m_addr[i] == miss_addr) hazard = 1;
      if ((ph[i] == P_WB || ph[i] == P_WAITB) && m_wba[i] == miss_addr) hazard = 1;
    end
    exp_mr   = (lowest(P_FREE) >= 0) && !hazard;
    exp_aw   = wb_sel >= 0 && !m_aws[wb_sel];
    exp_w    = wb_sel >= 0 && !m_ws[wb_sel];
    exp_ar   = ar_sel >= 0;
    exp_f    = fl_sel >= 0;
    exp_busy = 0;
    for (int i = 0; i < N; i++) if (ph[i] != P_FREE) exp_busy = 1;
    chk("miss_ready", miss_ready, exp_mr);
    chk("aw_valid", aw_valid, exp_aw);
    chk("w_valid", w_valid, exp_w);
    chk("ar_valid", ar_valid, exp_ar);
    chk("fill_valid", fill_valid, exp_f);
    chk("busy", busy, exp_busy);
    chk("err", err, m_err);
    chk("r_ready", r_ready, 1'b1);
    chk("b_ready", b_ready, 1'b1);
    if (exp_aw) begin
      chk("aw_addr", aw_addr, m_wba[wb_sel]);
      chk("aw_id", aw_id, wb_sel);
    end
    if (exp_w) chk("w_data", w_data, m_wbd[wb_sel]);
    if (exp_ar) begin
      chk("ar_addr", ar_addr, m_addr[ar_sel]);
      chk("ar_id", ar_id, ar_sel);
    end
    if (exp_f) begin
      chk("fill_addr", fill_addr, m_addr[fl_sel]);
      chk("fill_core", fill_core, m_core[fl_sel]);
      chk("fill_data", fill_data, m_rd[fl_sel]);
    end
    // advance the model
    for (int i = 0; i < N; i++) cur[i] = ph[i];
    if (miss_valid && exp_mr) begin
      s = lowest(P_FREE);
      ph[s] = miss_wb ? P_WB : P_AR;
      m_addr[s] = miss_addr; m_core[s] = miss_core; m_wba[s] = miss_wb_addr;
      m_wbd[s] = miss_wb_data; m_aws[s] = 0; m_ws[s] = 0;
    end
    if (wb_sel >= 0) begin
      if (exp_aw && aw_ready) m_aws[wb_sel] = 1;
      if (exp_w && w_ready)   m_ws[wb_sel] = 1;
      if (m_aws[wb_sel] && m_ws[wb_sel]) ph[wb_sel] = P_WAITB;
    end
    if (b_valid) begin
      if (cur[b_id] == P_WAITB) begin
        ph[b_id] = P_AR;
        if (b_resp != 0) m_err = 1;
      end else m_err = 1;
    end
    if (exp_ar && ar_ready) ph[ar_sel] = P_WAITR;
    if (r_valid) begin
      if (cur[r_id] == P_WAITR) begin
        ph[r_id] = P_FILL;
        m_rd[r_id] = r_data;
        if (r_resp != 0) m_err = 1;
      end else m_err = 1;
    end
    if (exp_f && fill_ready) ph[fl_sel] = P_FREE;
    wb_sel = pick(wb_sel, P_WB);
    ar_sel = pick(ar_sel, P_AR);
    fl_sel = pick(fl_sel, P_FILL);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic rand_inputs(input bit allow_err);
    int q[$];
    idle();
    miss_valid   = $urandom_range(0, 2) != 0;
    miss_addr    = 32'h1000 + ($urandom_range(0, 7) << 6);
    miss_core    = 2'($urandom_range(0, 3));
    miss_wb      = $urandom_range(0, 1) != 0;
    miss_wb_addr = 32'h1000 + ($urandom_range(0, 7) << 6);
    miss_wb_data = rand_line();
    ar_ready     = $urandom_range(0, 3) != 0;
    aw_ready     = $urandom_range(0, 2) != 0;
    w_ready      = $urandom_range(0, 2) != 0;
    fill_ready   = $urandom_range(0, 3) != 0;
    r_data       = rand_line();
    q = {};
    for (int i = 0; i < N; i++) if (ph[i] == P_WAITR) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
      r_valid = 1;
      r_id    = 2'(q[$urandom_range(0, q.size() - 1)]);
      r_resp  = (allow_err && $urandom_range(0, 9) == 0) ? 2'd2 : 2'd0;
    end else if (allow_err && $urandom_range(0, 19) == 0) begin
      q = {};
      for (int i = 0; i < N; i++) if (ph[i] != P_WAITR) q.push_back(i);
      if (q.size() > 0) begin
        r_valid = 1;
        r_id    = 2'(q[$urandom_range(0, q.size() - 1)]);
      end
    end
    q = {};
    for (int i = 0; i < N; i++) if (ph[i] == P_WAITB) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
      b_valid = 1;
      b_id    = 2'(q[$urandom_range(0, q.size() - 1)]);
      b_resp  = (allow_err && $urandom_range(0, 9) == 0) ? 2'd2 : 2'd0;
    end else if (allow_err && $urandom_range(0, 19) == 0) begin
      q = {};
      for (int i = 0; i < N; i++) if (ph[i] != P_WAITB) q.push_back(i);
      if (q.size() > 0) begin
        b_valid = 1;
        b_id    = 2'(q[$urandom_range(0, q.size() - 1)]);
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ar_valid"}, ar_valid, 1'b0);
    chk({tag, "_ar_addr"}, ar_addr, 32'h0);
    chk({tag, "_ar_id"}, ar_id, 2'd0);
    chk({tag, "_aw_valid"}, aw_valid, 1'b0);
    chk({tag, "_aw_addr"}, aw_addr, 32'h0);
    chk({tag, "_w_valid"}, w_valid, 1'b0);
    chk({tag, "_w_data"}, w_data, '0);
    chk({tag, "_fill_valid"}, fill_valid, 1'b0);
    chk({tag, "_fill_data"}, fill_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_r_ready"}, r_ready, 1'b1);
    chk({tag, "_b_ready"}, b_ready, 1'b1);
    chk({tag, "_miss_ready"}, miss_ready, 1'b1);
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    idle();
    model_reset();
    #1;
    reset_checks(tag);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [LB-1:0] line_a5, line_5a;
    line_a5 = {64{8'hA5}};
    line_5a = {64{8'h5A}};
    idle();
    model_reset();
    @(negedge clk_i);
    do_reset("rst");

    // clean miss, no writeback
    miss_valid = 1; miss_addr = 32'h1000; miss_core = 2; ar_ready = 1;
    step();
    idle(); ar_ready = 1;
    chk("clean_ar_addr", ar_addr, 32'h1000);
    step();
    idle(); step(); step();
    r_valid = 1; r_id = 0; r_data = line_a5;
    step();
    idle(); fill_ready = 1;
    chk("clean_fill_data", fill_data, line_a5);
    chk("clean_fill_core", fill_core, 2'd2);
    step();
    idle(); step();

    // dirty writeback, W accepted one cycle after AW
    miss_valid = 1; miss_addr = 32'h2000; miss_core = 1; miss_wb = 1;
    miss_wb_addr = 32'h3000; miss_wb_data = line_5a;
    step();
    idle(); aw_ready = 1;
    chk("wb_aw_addr", aw_addr, 32'h3000);
    step();
    idle(); w_ready = 1;
    chk("wb_w_data", w_data, line_5a);
    step();
    idle(); step();
    b_valid = 1; b_id = 0;
    step();
    idle(); ar_ready = 1;
    chk("wb_ar_addr", ar_addr, 32'h2000);
    step();
    idle(); r_valid = 1; r_id = 0; r_data = rand_line();
    step();
    idle(); fill_ready = 1;
    chk("wb_fill_addr", fill_addr, 32'h2000);
    step();
    idle(); step();

    // random traffic without error responses
    for (int c = 0; c < 1500 && n_mis < 50; c++) begin
      rand_inputs(1'b0);
      step();
    end
    // random traffic with error responses and stray IDs
    for (int c = 0; c < 1000 && n_mis < 50; c++) begin
      rand_inputs(1'b1);
      step();
    end
    // asynchronous reset in the middle of traffic
    do_reset("midrst");
    for (int c = 0; c < 400 && n_mis < 50; c++) begin
      rand_inputs(1'b0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_miss_ctrl.md
Name: l2_miss_ctrl

Overview:
- Miss-status holding register (MSHR) controller between the L2 cache lookup pipeline and the DRAM AXI4 master interface.
- Accepts L2 misses, each with an optional dirty-victim writeback.
- Sequences the writeback (AW/W/B), then the line fetch (AR/R), then returns the filled line to the L2 for install.
- Tracks up to NUM_MSHR outstanding misses, using the AXI ID as the MSHR index.

Parameters:
- NUM_MSHR, 4: number of outstanding miss entries (power of 2).
- ADDR_W, 32: byte address width; all addresses are line-aligned.
- LINE_BITS, 512: cache line width; one AXI beat carries one line.
- CORE_W, 2: width of the requesting core ID.
- ID_W, 2: AXI ID width, equal to clog2(NUM_MSHR).

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- miss_valid  in  1  L2 presents a miss.
- miss_ready  out  1  miss accepted when miss_valid is also high.
- miss_addr  in  ADDR_W  missing line address.
- miss_core  in  CORE_W  requesting core.
- miss_wb  in  1  a dirty victim must be written back first.
- miss_wb_addr  in  ADDR_W  victim line address.
- miss_wb_data  in  LINE_BITS  victim line data.
- fill_valid  out  1  filled line available.
- fill_ready  in  1  L2 accepts the fill.
- fill_addr  out  ADDR_W  filled line address.
- fill_core  out  CORE_W  core that missed.
- fill_data  out  LINE_BITS  line data.
- ar_valid / ar_ready  out / in  1  AXI read-address handshake.
- ar_addr  out  ADDR_W  read address.
- ar_id  out  ID_W  read ID.
- r_valid  in  1  AXI read data valid.
- r_ready  out  1  read data ready.
- r_id  in  ID_W  read data ID.
- r_data  in  LINE_BITS  read data.
- r_resp  in  2  read response.
- aw_valid / aw_ready  out / in  1  AXI write-address handshake.
- aw_addr  out  ADDR_W  write address.
- aw_id  out  ID_W  write ID.
- w_valid / w_ready  out / in  1  AXI write-data handshake.
- w_data  out  LINE_BITS  write data.
- b_valid  in  1  AXI write response valid.
- b_ready  out  1  write response ready.
- b_id  in  ID_W  write response ID.
- b_resp  in  2  write response.
- busy  out  1  at least one entry is not FREE.
- err  out  1  sticky error flag.

Behaviour:
- **Reset (reset low, asynchronous):** every entry goes FREE and err clears. Reset values of all outputs:
  - 0: ar_valid, aw_valid, w_valid, fill_valid, busy, err and all address/ID/data outputs.
  - 1: r_ready, b_ready.
  - miss_ready is driven from registered state, so it reads 1 once state is FREE.
- **Reset mid-operation:** all entries are discarded. DRAM is reset together with this block, so stale R/B beats are not handled.
- **Per-entry state:** FREE, WB, WB_RSP, RD_REQ, RD_WAIT, FILL. Each entry also holds addr, core, wb_addr, a LINE_BITS buffer, aw_done and w_done.
- **Allocation:**
  - miss_ready = (some entry FREE) AND (miss_addr matches no non-FREE entry's addr) AND (miss_addr matches no wb_addr of an entry in WB/WB_RSP). A conflicting miss stalls.
  - miss_ready is computed from registered state only. An entry freed in cycle T is allocatable from T+1.
  - On accept, the lowest-index FREE entry is loaded.
  - If miss_wb=1: state WB, buffer = miss_wb_data. Otherwise state RD_REQ.
- **WB (writeback issue):**
  - The lowest-index entry in WB drives aw_* and w_* (aw_id = entry index). The AW and W handshakes complete independently; aw_done and w_done are set on each.
  - Once a channel has handshaken it deasserts for that entry. When both are done, the entry moves to WB_RSP.
  - A selected entry holds valid/addr/data stable until ready; selection never changes while either valid is pending.
- **WB_RSP:** b_ready is tied high. On b_valid with b_id pointing at an entry in WB_RSP, that entry moves to RD_REQ. b_resp != 0 sets err; the entry still proceeds.
- **RD_REQ:**
  - The lowest-index entry in RD_REQ drives ar_valid, ar_addr = entry addr, ar_id = index.
  - Held stable until ar_ready; then the entry moves to RD_WAIT.
  - ar_valid is registered: a miss accepted in cycle T (no writeback) shows ar_valid at T+1.
- **RD_WAIT:**
  - r_ready is tied high.
  - On r_valid, the entry r_id points at (in RD_WAIT) captures r_data into its buffer and moves to FILL.
  - Responses may return out of order.
  - r_resp != 0 sets err; the data is still filled.
- **FILL:**
  - The lowest-index entry in FILL drives fill_valid and fill_* the cycle after its R beat. Output is stable until fill_ready.
  - On handshake the entry goes FREE.
  - fill_valid may stay high back-to-back for the next FILL entry.
- **Unexpected IDs:** an r_id/b_id whose entry is not in RD_WAIT/WB_RSP sets err; the beat is dropped and no state changes.
- **Simultaneous events:** accept, AR, AW, W, R, B and fill handshakes can all occur in one cycle on different entries, and all take effect.
- **busy** is the registered OR of entries not FREE.

Test Plan:
- Clean miss, no writeback: miss addr 0x1000, core 2, ar_ready=1, R 3 cycles later with data 0xA5..., id 0, resp 0 → ar_valid at T+1 with addr 0x1000, id 0; fill_valid the cycle after R with addr 0x1000, core 2, data 0xA5...; entry FREE; busy=0.
- Dirty writeback: miss 0x2000 with wb_addr 0x3000, data 0x5A...; w_ready one cycle after aw_ready → AW/W addr 0x3000, data 0x5A, id 0; ar_valid only after B; fill returns 0x2000.
- Out-of-order responses: four misses 0x0/0x40/0x80/0xC0 fill the MSHRs → miss_ready=0; R returns ids 3,1,0,2 → fills occur in that order and miss_ready rises the cycle after the first fill handshake.
- Conflicts: a miss to 0x1000 while 0x1000 is pending stalls; a miss to 0x3000 while writeback 0x3000 awaits B stalls → both accepted only after the respective entry leaves the conflicting state.
- Error paths: r_resp=2 → err=1 and the fill is still delivered; a b_valid with an unused id → err=1 and no state change; async reset mid-flight → all outputs 0, r_ready/b_ready=1, busy=0.
- Backpressure: ar_ready held low 5 cycles and fill_ready low 3 cycles → ar_addr/ar_id and fill_* stay stable throughout and handshakes complete once.
